countdown_timer: RTL

Minutes:seconds countdown timer for the board's 7-segment display and LEDs. It is the down-counting companion to the time-of-day clock. It takes a minute preset from switches, and start/pause and load commands from push buttons. It counts down once per second to 00:00, then raises a flashing alarm. All logic runs on the 50 MHz board clock: a one-cycle tick enable drives the countdown, and no derived clock is used.

---
 rtl/countdown_timer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: minutes:seconds countdown for the 7-segment display.
//
// A minute preset comes from SW. Two debounced push buttons drive the timer:
// KEY1 starts or pauses it, and KEY2 loads the preset. The time counts down
// once per second to 00:00, then the alarm LED lights and the digits flash.
// Everything runs on CLOCK_50, and a one-cycle tick enables each countdown
// step, so there is no derived clock.
//
// Ports:
//   CLOCK_50  in   1  board clock
//   KEY0      in   1  asynchronous active-low reset
//   KEY1      in   1  start/pause button, active-low
//   KEY2      in   1  load button, active-low
//   SW        in   7  minute preset, clamped to 99
//   HEX0..3   out  7  sec ones, sec tens, min ones, min tens (active-low {g..a})
//   LEDR      out  2  [0] running, [1] alarm

// CountdownKeyDebounce: synchronises one active-low button and debounces it.
// It emits a one-cycle press pulse when the accepted level falls.
//
// Ports:
//   clk_i    in   1  clock
//   rstN_i   in   1  asynchronous active-low reset
//   keyN_i   in   1  raw button, active-low
//   press_o  out  1  one-cycle pulse per accepted press
module CountdownKeyDebounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rstN_i,
    input  logic keyN_i,
    output logic press_o
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    // Synchroniser, accepted level, run-length counter and press pulse.
    // Reset makes the button look released, with nothing pending.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], keyN_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Count the consecutive cycles in which the synchronised level differs
    // from the accepted one. Any cycle where they agree restarts the count,
    // so a bounce shorter than DB_CYCLES is never accepted. Only a falling
    // acceptance (a press) produces a pulse.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

module countdown_timer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic [6:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [1:0] LEDR
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] HALF     = PW'(CLK_HZ / 2);
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] flash_q, flash_d;

    logic       startP, loadP;
    logic [6:0] presetMin;
    logic       reachZero;
    logic       blank;
    logic [6:0] secW;

    CountdownKeyDebounce #(.DB_CYCLES(DB_CYCLES)) startKey (
        .clk_i   (CLOCK_50),
        .rstN_i  (KEY0),
        .keyN_i  (KEY1),
        .press_o (startP)
    );

    CountdownKeyDebounce #(.DB_CYCLES(DB_CYCLES)) loadKey (
        .clk_i   (CLOCK_50),
        .rstN_i  (KEY0),
        .keyN_i  (KEY2),
        .press_o (loadP)
    );

    assign presetMin = (SW > 7'd99) ? 7'd99 : SW;

    // State and counter registers. Reset clears everything immediately,
    // so the display shows 00:00 without waiting for a clock edge.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q <= IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            presc_q <= '0;
            flash_q <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            presc_q <= presc_d;
            flash_q <= flash_d;
        end
    end

    // Next-state logic. Load wins over start whenever it is honoured. In RUN
    // the prescaler advances on every RUN cycle, including the cycle in which
    // the pause arrives. PAUSE freezes it, including on the resume edge, so
    // the cycles spent in RUN always add up to CLK_HZ per second. The flash
    // counter runs only in DONE, so it is zero on entry.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        flash_d   = '0;
        reachZero = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (loadP) begin
                    min_d = presetMin;
                    sec_d = '0;
                end else if (startP && (min_q != '0 || sec_q != '0)) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    if (sec_q != '0) begin
                        sec_d = sec_q - 1'b1;
                    end else begin
                        sec_d = 6'd59;
                        min_d = min_q - 1'b1;
                    end
                    reachZero = (min_q == '0) && (sec_q == 6'd1);
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (reachZero) begin
                    state_d = DONE;
                end else if (startP) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (loadP) begin
                    min_d   = presetMin;
                    sec_d   = '0;
                    state_d = IDLE;
                end else if (startP) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                flash_d = (flash_q == PRE_LAST) ? '0 : flash_q + 1'b1;
                if (loadP) begin
                    min_d   = presetMin;
                    sec_d   = '0;
                    state_d = IDLE;
                end else if (startP) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit decoder; anything outside 0-9 shows blank.
    function automatic logic [6:0] segOf(input logic [6:0] d);
        case (d)
            7'd0:    segOf = 7'b1000000;
            7'd1:    segOf = 7'b1111001;
            7'd2:    segOf = 7'b0100100;
            7'd3:    segOf = 7'b0110000;
            7'd4:    segOf = 7'b0011001;
            7'd5:    segOf = 7'b0010010;
            7'd6:    segOf = 7'b0000010;
            7'd7:    segOf = 7'b1111000;
            7'd8:    segOf = 7'b0000000;
            7'd9:    segOf = 7'b0010000;
            default: segOf = SEG_BLANK;
        endcase
    endfunction

    // The display is decoded straight from the registers. In DONE, the first
    // half of each flash period shows 00:00 and the second half is blank.
    assign blank = (state_q == DONE) && (flash_q >= HALF);
    assign secW  = {1'b0, sec_q};

    assign HEX0 = blank ? SEG_BLANK : segOf(secW % 7'd10);
    assign HEX1 = blank ? SEG_BLANK : segOf(secW / 7'd10);
    assign HEX2 = blank ? SEG_BLANK : segOf(min_q % 7'd10);
    assign HEX3 = blank ? SEG_BLANK : segOf(min_q / 7'd10);

    assign LEDR = {state_q == DONE, state_q == RUN};

endmodule
